// File: rtl/mod7_sched.sv
// mod7_sched: round-robin front end for a serial mod-7 residue engine with valid/ready result port.
// Define MOD7_SCHED_EARLY_DONE_EN to end SHIFT as soon as the remaining operand bits are all zero.
module mod7_sched #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 12,
  localparam int IDW  = $clog2(NREQ),
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [2:0]              res_data,
  output logic [IDW-1:0]          res_id,
  output logic                    busy
);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_sh;
  logic [2:0]       r_acc, r_wt, r_res_data;
  logic [CW-1:0]    r_cnt;
  logic [IDW-1:0]   r_last, r_res_id, w_gid;
  logic [NREQ-1:0]  w_gnt;
  logic             w_hit, w_last;
  logic [3:0]       w_sum;
  logic [2:0]       w_acc;
  // first valid requester after the last one granted wins
  always_comb begin
    w_hit = 1'b0;
    w_gid = '0;
    for (int k = 1; k <= NREQ; k++) begin
      logic [IDW-1:0] idx;
      idx = IDW'((int'(r_last) + k) % NREQ);
      if (!w_hit && req_valid[idx]) begin
        w_hit = 1'b1;
        w_gid = idx;
      end
    end
    w_gnt = w_hit ? (NREQ'(1) << w_gid) : '0;
  end
  assign w_sum = {1'b0, r_acc} + (r_sh[0] ? {1'b0, r_wt} : 4'd0);
  assign w_acc = (w_sum >= 4'd7) ? 3'(w_sum - 4'd7) : w_sum[2:0];
`ifdef MOD7_SCHED_EARLY_DONE_EN
  assign w_last = (r_cnt == CW'(WIDTH - 1)) || ((r_sh >> 1) == '0);
`else
  assign w_last = (r_cnt == CW'(WIDTH - 1));
`endif
  assign req_ready = (r_state == S_IDLE && rst_n) ? w_gnt : '0;
  assign res_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sh       <= '0;
      r_acc      <= '0;
      r_wt       <= 3'd1;
      r_cnt      <= '0;
      r_last     <= IDW'(NREQ - 1);
      r_res_data <= '0;
      r_res_id   <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_hit) begin
        r_sh     <= req_data[w_gid*WIDTH +: WIDTH];
        r_res_id <= w_gid;
        r_last   <= w_gid;
        r_acc    <= '0;
        r_wt     <= 3'd1;
        r_cnt    <= '0;
        r_state  <= S_SHIFT;
      end
    end else if (r_state == S_SHIFT) begin
      r_acc <= w_acc;
      r_wt  <= {r_wt[1:0], r_wt[2]};
      r_sh  <= r_sh >> 1;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_res_data <= w_acc;
        r_state    <= S_DONE;
      end
    end else if (res_ready) begin
      r_state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_mod7_sched.sv
// tb_mod7_sched: scenario tasks checking mod7_sched against an arithmetic residue/round-robin model.
module tb_mod7_sched;
  localparam int NREQ = 2;
  localparam int W    = 12;
  localparam int IDW  = $clog2(NREQ);
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [2:0]        res_data;
  logic [IDW-1:0]    res_id;
  logic              busy;
  int n_cmp = 0;
  int n_bad = 0;

  mod7_sched #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [W-1:0] d);
`ifdef MOD7_SCHED_EARLY_DONE_EN
    int m = 0;
    for (int b = 0; b < W; b++) if (d[b]) m = b + 1;
    return (m < 1) ? 1 : m;
`else
    return W;
`endif
  endfunction

  function automatic int res7(input logic [W-1:0] d);
    return int'(d) % 7;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // present an operand, wait for the grant, then count edges to res_valid
  task automatic send(input int i, input logic [W-1:0] d, output int wait_n, output int lat);
    req_data[i*W +: W] = d;
    req_valid[i] = 1'b1;
    #1;
    wait_n = 0;
    while (!req_ready[i] && wait_n < 50) begin
      @(posedge clk); #1; wait_n++;
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic drain();
    int n = 0;
    res_ready = 1'b1;
    while (busy && n < 100) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '1;
    #2;
    n_cmp++;
    if (req_ready !== '0) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_cmp++;
    if ({res_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL reset_valid_busy: got %b want 00", {res_valid, busy}); end
    n_cmp++;
    if (res_data !== 3'd0 || res_id !== '0) begin n_bad++; $display("FAIL reset_res: got data %0d id %0d want 0 0", res_data, res_id); end
    req_valid = '0;
    do_reset();
  endtask

  task automatic test_single();
    int wn, lat;
    do_reset();
    send(0, 12'd100, wn, lat);
    n_cmp++;
    if (wn !== 0) begin n_bad++; $display("FAIL single_ready_same_cycle: got wait %0d want 0", wn); end
    n_cmp++;
    if (lat !== exp_lat(12'd100)) begin n_bad++; $display("FAIL single_latency: got %0d want %0d", lat, exp_lat(12'd100)); end
    n_cmp++;
    if (res_data !== 3'd2 || res_id !== '0) begin n_bad++; $display("FAIL single_result: got data %0d id %0d want 2 0", res_data, res_id); end
    drain();
  endtask

  task automatic test_wrap();
    logic [W-1:0] ops [3];
    int wn, lat;
    ops[0] = 12'hFFF; ops[1] = 12'd6; ops[2] = 12'd7;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      send(0, ops[k], wn, lat);
      n_cmp++;
      if (lat !== exp_lat(ops[k]) || int'(res_data) !== res7(ops[k])) begin
        n_bad++; $display("FAIL wrap_%0d: got lat %0d data %0d want lat %0d data %0d", k, lat, res_data, exp_lat(ops[k]), res7(ops[k]));
      end
      drain();
    end
  endtask

  task automatic test_arbitration();
    logic [W-1:0] ops [NREQ];
    int got = 0;
    int cyc = 0;
    do_reset();
    ops[0] = 12'd10; ops[1] = 12'd20;
    for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = ops[i];
    req_valid = '1;
    #1;
    while (got < 3 && cyc < 200) begin
      n_cmp++;
      if (!$onehot0(req_ready)) begin n_bad++; $display("FAIL arb_onehot: got %b want at most one bit", req_ready); end
      if (res_valid) begin
        n_cmp++;
        if (int'(res_id) !== got % NREQ || int'(res_data) !== res7(ops[got % NREQ])) begin
          n_bad++; $display("FAIL arb_result_%0d: got id %0d data %0d want id %0d data %0d", got, res_id, res_data, got % NREQ, res7(ops[got % NREQ]));
        end
        got++;
      end
      @(posedge clk); #1; cyc++;
    end
    n_cmp++;
    if (got !== 3) begin n_bad++; $display("FAIL arb_count: got %0d results want 3", got); end
    req_valid = '0;
    drain();
  endtask

  task automatic test_backpressure();
    int wn, lat;
    logic [2:0] d0;
    logic [IDW-1:0] id0;
    do_reset();
    res_ready = 1'b0;
    send(1, 12'd1234, wn, lat);
    n_cmp++;
    if (lat !== exp_lat(12'd1234) || int'(res_data) !== res7(12'd1234) || res_id !== IDW'(1)) begin
      n_bad++; $display("FAIL bp_result: got lat %0d data %0d id %0d want %0d %0d 1", lat, res_data, res_id, exp_lat(12'd1234), res7(12'd1234));
    end
    d0 = res_data; id0 = res_id;
    req_data[0 +: W] = 12'd55;
    req_valid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (!res_valid || res_data !== d0 || res_id !== id0 || req_ready !== '0 || !busy) begin
        n_bad++; $display("FAIL bp_hold_%0d: got v %b data %0d id %0d rdy %b busy %b", c, res_valid, res_data, res_id, req_ready, busy);
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (res_valid || busy || req_ready !== 2'b01) begin
      n_bad++; $display("FAIL bp_release: got v %b busy %b rdy %b want 0 0 01", res_valid, busy, req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    n_cmp++;
    if (!busy || res_id !== '0) begin n_bad++; $display("FAIL bp_next_accept: got busy %b id %0d want 1 0", busy, res_id); end
    drain();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    int wn, lat;
    do_reset();
    req_data[W +: W] = 12'd3000;
    req_valid = 2'b10;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (5) @(posedge clk);
    #3;
    req_valid = '1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({res_valid, busy} !== 2'b00 || req_ready !== '0 || res_id !== '0 || res_data !== 3'd0) begin
      n_bad++; $display("FAIL mid_reset_outputs: got v %b busy %b rdy %b id %0d data %0d", res_valid, busy, req_ready, res_id, res_data);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    req_valid = '0;
    for (int c = 0; c < W + 3; c++) begin
      @(posedge clk); #1;
      if (res_valid || busy) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL mid_stale_result: got %0d active cycles want 0", seen); end
    req_data[W +: W] = 12'd77;
    req_valid[1] = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 2'b10) begin n_bad++; $display("FAIL mid_lone_req1: got %b want 10", req_ready); end
    req_valid[1] = 1'b0;
    send(0, 12'd200, wn, lat);
    n_cmp++;
    if (res_id !== '0 || int'(res_data) !== res7(12'd200)) begin
      n_bad++; $display("FAIL mid_first_grant: got id %0d data %0d want 0 %0d", res_id, res_data, res7(12'd200));
    end
    drain();
  endtask

  task automatic test_latency_ops();
    logic [W-1:0] ops [2];
    int wn, lat;
    ops[0] = 12'd5; ops[1] = 12'd0;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      send(0, ops[k], wn, lat);
      n_cmp++;
      if (lat !== exp_lat(ops[k]) || int'(res_data) !== res7(ops[k])) begin
        n_bad++; $display("FAIL latency_op_%0d: got lat %0d data %0d want lat %0d data %0d", k, lat, res_data, exp_lat(ops[k]), res7(ops[k]));
      end
      drain();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ops [NREQ];
    logic [NREQ-1:0] mask;
    int last = NREQ - 1;
    int exp_id, lat, hold;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        ops[i] = W'($urandom_range(0, (1 << W) - 1));
        req_data[i*W +: W] = ops[i];
      end
      req_valid = mask;
      exp_id = -1;
      for (int k = 1; k <= NREQ; k++)
        if (exp_id < 0 && mask[(last + k) % NREQ]) exp_id = (last + k) % NREQ;
      #1;
      n_cmp++;
      if (req_ready !== NREQ'(1 << exp_id)) begin n_bad++; $display("FAIL rand_grant_%0d: got %b want id %0d", it, req_ready, exp_id); end
      @(posedge clk); #1;
      req_valid = '0;
      last = exp_id;
      hold = $urandom_range(0, 3);
      res_ready = (hold == 0);
      lat = 0;
      while (!res_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      n_cmp++;
      if (lat !== exp_lat(ops[exp_id]) || int'(res_id) !== exp_id || int'(res_data) !== res7(ops[exp_id])) begin
        n_bad++; $display("FAIL rand_result_%0d: got lat %0d id %0d data %0d want %0d %0d %0d", it, lat, res_id, res_data, exp_lat(ops[exp_id]), exp_id, res7(ops[exp_id]));
      end
      for (int c = 0; c < hold; c++) begin
        @(posedge clk); #1;
        n_cmp++;
        if (!res_valid || int'(res_data) !== res7(ops[exp_id])) begin n_bad++; $display("FAIL rand_hold_%0d: got v %b data %0d", it, res_valid, res_data); end
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (res_valid || busy) begin n_bad++; $display("FAIL rand_return_idle_%0d: got v %b busy %b", it, res_valid, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    test_latency_ops();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mod7_sched.md
# mod7_sched

Round-robin scheduler that shares one serial modulo-7 residue engine between `NREQ` requesters. Each granted operand is fed LSB-first, one bit per clock, with the bit weight rotating 1→2→4→1 (2^k mod 7). The block accumulates the residue, then returns it tagged with the requester index over a valid/ready result port. It sits in front of the serial residue datapath and owns operand framing, bit sequencing, weight phase alignment and result hand-off.

## Interface
- `NREQ`, 2, number of requesters (≥2)
- `WIDTH`, 12, operand width in bits (≥1)
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `req_valid` input NREQ: bit i = requester i has an operand
- `req_data` input NREQ*WIDTH: operand i in `[i*WIDTH +: WIDTH]`, unsigned
- `req_ready` output NREQ: one-hot grant/accept, combinational
- `res_valid` output 1: residue available
- `res_ready` input 1: consumer accepts residue
- `res_data` output 3: residue, 0..6
- `res_id` output $clog2(NREQ): index of requester owning `res_data`
- `busy` output 1: state ≠ IDLE

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **Reset:** `rst_n` low at any time, including mid-SHIFT or mid-DONE, immediately forces the following, and any in-flight operand is discarded:
  - state = IDLE
  - `res_valid` = 0, `res_data` = 0, `res_id` = 0, `busy` = 0
  - `req_ready` = 0
  - accumulator = 0, weight = 1, bit counter = 0
  - round-robin pointer `last` = NREQ-1, so requester 0 wins first
- **IDLE:**
  - Priority order is `last+1`, `last+2`, … mod NREQ; the first requester with `req_valid` set is granted.
  - `req_ready[g]` = 1 combinationally; all other `req_ready` bits are 0.
  - On the clock edge with `req_valid[g] & req_ready[g]`:
    - capture `req_data[g]` into the shift register and `g` into `res_id`
    - accumulator = 0, weight = 1, counter = 0
    - `last` = g
    - go to SHIFT
  - No valid requests: stay in IDLE.
- **SHIFT:** each edge consumes shift-register bit 0.
  - sum = acc + (bit ? weight : 0), range 0..10 (4-bit intermediate)
  - acc = (sum ≥ 7) ? sum − 7 : sum. The accumulator never holds 7; the value 7 wraps to 0.
  - weight rotates 1→2→4→1.
  - The shift register shifts right and the counter increments.
  - After the bit with counter = WIDTH−1, move acc into `res_data` and go to DONE.
- **DONE:**
  - `res_valid` = 1.
  - `res_data` and `res_id` are held stable until `res_ready` = 1.
  - On the handshake edge, go to IDLE.
- `req_ready` is 0 in SHIFT and DONE.
- Requesters hold `req_valid` and `req_data` stable until accepted; an ungranted requester keeps waiting.
- After leaving DONE, `res_data` and `res_id` keep their last values; they are meaningful only while `res_valid` = 1.

## Timing
- The accept edge is E0. Bit k is processed at edge E(k+1).
- `res_valid` rises after edge E(WIDTH), i.e. latency is WIDTH cycles from accept to `res_valid`.
- Minimum spacing between accepts is WIDTH+2 cycles: WIDTH SHIFT cycles, 1 DONE cycle with `res_ready` high, and 1 IDLE cycle.
- The `res_ready` → `req_ready` path has no combinational dependency.
- `req_valid` → `req_ready` is combinational; no other input-to-output combinational path exists.
- Simultaneous requests: exactly one grant per IDLE cycle, in strict round-robin order. With every requester continuously valid, grants rotate 0,1,…,NREQ−1,0.

## Configuration
- `MOD7_SCHED_EARLY_DONE_EN` defined:
  - SHIFT exits to DONE after the first edge at which the remaining (post-shift) register is all zero.
  - Latency = max(1, index of highest set bit + 1).
  - An all-zero operand takes 1 SHIFT cycle and yields residue 0.
  - Residue values are identical to the non-early behaviour.
- Undefined: SHIFT always runs exactly WIDTH cycles, regardless of operand value.

## Test plan
- **Single request:** after reset, requester 0 presents 100 → `req_ready[0]` high in the same cycle. `res_valid` asserts after 12 edges with `res_data` = 2 and `res_id` = 0.
- **Wrap-around:** operand 12'hFFF (4095) → `res_data` = 0; confirms the accumulator never reaches 7. Operand 6 → `res_data` = 6.
- **Arbitration:** both requesters held valid from reset, requester 0 with 10 and requester 1 with 20.
  - Results return in order (id0, 3), (id1, 6), then (id0, 3) again.
  - `req_ready` is never two-hot.
- **Backpressure:** `res_ready` held low for 5 cycles in DONE → `res_valid`, `res_data` and `res_id` stay stable, `req_ready` stays 0, and no accept occurs.
  - Releasing `res_ready` returns the block to IDLE on the next edge; the next accept follows one cycle later.
- **Reset mid-operation:** `rst_n` pulsed low during bit 5 of an operand.
  - All outputs go to 0 asynchronously.
  - After release, requester 0 is granted first and the old operand never produces a result.
- **Early done:** with `MOD7_SCHED_EARLY_DONE_EN`:
  - operand 5 → `res_data` = 5 after 3 edges
  - operand 0 → `res_data` = 0 after 1 edge
  - Without the macro, both operands take 12 edges.
